// File: rtl/chaser_pkg.sv
// Shared constants for the chaser: raw switch bit positions and input-conditioning defaults.
package chaser_pkg;

    localparam int RAW_WIDTH  = 6;
    localparam int SPEED_LSB  = 0;
    localparam int SPEED_MSB  = 2;
    localparam int TAIL_BIT   = 3;
    localparam int DIR_BIT    = 4;
    localparam int INVERT_BIT = 5;

    localparam int DEFAULT_TICK_WIDTH     = 10;
    localparam int DEFAULT_DEBOUNCE_COUNT = 4;

endpackage

// File: rtl/chaser_debounce_bit.sv
// One switch input: two-flop synchroniser followed by a stable register.
// CHASER_INPUT_DEBOUNCE_EN adds a per-bit match counter qualified on sample ticks.
module chaser_debounce_bit #(
    parameter int DEBOUNCE_COUNT = chaser_pkg::DEFAULT_DEBOUNCE_COUNT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_tick,
    input  logic raw,
    output logic stable
);

    logic sync_meta;
    logic sync_out;

    if (DEBOUNCE_COUNT < 1 || DEBOUNCE_COUNT > 15) begin : g_bad_count
        $error("chaser_debounce_bit: DEBOUNCE_COUNT must be 1..15");
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

`ifdef CHASER_INPUT_DEBOUNCE_EN
    localparam logic [3:0] MATCH_TARGET = 4'(DEBOUNCE_COUNT);

    logic [3:0] match_count;
    logic [3:0] match_next;

    assign match_next = match_count + 4'd1;

    // Any tick that agrees with the current level restarts qualification.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable      <= 1'b0;
            match_count <= 4'd0;
        end else if (sample_tick) begin
            if (sync_out != stable) begin
                if (match_next == MATCH_TARGET) begin
                    stable      <= sync_out;
                    match_count <= 4'd0;
                end else begin
                    match_count <= match_next;
                end
            end else begin
                match_count <= 4'd0;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable <= 1'b0;
        end else if (sample_tick) begin
            stable <= sync_out;
        end
    end
`endif

endmodule

// File: rtl/chaser_input_cond.sv
// Conditions the six chaser switch inputs and pulses cfg_strobe after any conditioned change.
// CHASER_INPUT_DEBOUNCE_EN enables the sample prescaler and debounce counters.
module chaser_input_cond
    import chaser_pkg::*;
#(
    parameter int TICK_WIDTH     = DEFAULT_TICK_WIDTH,
    parameter int DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] raw_in,
    output logic [2:0] speed,
    output logic       tail,
    output logic       direction,
    output logic       led_invert,
    output logic       cfg_strobe
);

    logic                 sample_tick;
    logic [RAW_WIDTH-1:0] stable_vec;
    logic [RAW_WIDTH-1:0] prev_stable;

    if (TICK_WIDTH < 1) begin : g_bad_tick
        $error("chaser_input_cond: TICK_WIDTH must be at least 1");
    end

`ifdef CHASER_INPUT_DEBOUNCE_EN
    logic [TICK_WIDTH-1:0] prescaler;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign sample_tick = &prescaler;
`else
    // Without debouncing every clock is a sample point.
    assign sample_tick = 1'b1;
`endif

    for (genvar i = 0; i < RAW_WIDTH; i++) begin : g_bit
        chaser_debounce_bit #(
            .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
        ) u_bit (
            .clk        (clk),
            .reset_n    (reset_n),
            .sample_tick(sample_tick),
            .raw        (raw_in[i]),
            .stable     (stable_vec[i])
        );
    end

    // prev_stable clears with the stable bits, so leaving reset never strobes by itself.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_stable <= '0;
            cfg_strobe  <= 1'b0;
        end else begin
            prev_stable <= stable_vec;
            cfg_strobe  <= |(stable_vec ^ prev_stable);
        end
    end

    assign speed      = stable_vec[SPEED_MSB:SPEED_LSB];
    assign tail       = stable_vec[TAIL_BIT];
    assign direction  = stable_vec[DIR_BIT];
    assign led_invert = stable_vec[INVERT_BIT];

endmodule
